pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the generic N-bit carry-lookahead adder.
- Splits an nBITS add/subtract into GROUP-bit lookahead groups. The groups are spread across STAGES register stages.
- Each stage forwards its group carry to the next stage.
- Valid/ready handshake on input and output, with full backpressure.
- Sits between operand sources and result consumers in the datapath, as the drop-in adder when timing closure needs pipelining.

Parameters:
- nBITS, 16, operand and result width; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group (local generate/propagate, group G/P).
- STAGES, 2, pipeline stages. Requires 1 <= STAGES <= nBITS/GROUP and (nBITS/GROUP) % STAGES == 0. Latency equals STAGES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operand set this cycle
- ain  input  nBITS  operand A
- bin  input  nBITS  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: A+B+cin; 1: A-B-cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  nBITS  result bits
- cout  output  1  carry-out; in sub mode, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (sampled at rising edge while reset=1):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0.
  - First cycle after reset: in_ready=1.
  - In-flight operations are discarded; no partial result ever appears.
  - reset overrides any simultaneous handshake.
- Operand conditioning at input:
  - b_eff = sub ? ~bin : bin
  - c0 = sub ? ~cin : cin
  - sub=1 therefore yields A + ~B + !cin = A - B - cin mod 2^nBITS.
- Pipeline slicing:
  - nG = nBITS/GROUP groups; each stage owns nG/STAGES consecutive groups, LSB first.
  - Stage k computes sum bits and group carries for its groups using lookahead over its own groups.
  - Stage k registers its sum slice, its outgoing carry, and the unprocessed upper operand bits (skew registers).
  - No ripple across stage boundaries within one cycle.
- Outputs:
  - The final stage registers are the output registers: sum, cout, out_valid.
  - ovf = carry into MSB XOR carry out of MSB, registered with sum.
- Latency: operand transferred at edge E (in_valid & in_ready) gives out_valid=1 in the cycle after edge E+STAGES-1, with no stall.
- Flow control (global stall):
  - advance = !out_valid | out_ready
  - in_ready = advance (combinational from out_ready and state)
  - When advance=0, every stage register, including valid bits and data, holds.
  - When advance=1, every stage shifts one step. A stage receives valid=0 when in_valid=0 (bubble).
- Throughput: one result per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf stay stable.
- Simultaneous events:
  - in_valid with out_ready on a full pipe: accept and retire in the same cycle.
  - in_valid=1 with in_ready=0: no transfer; the source must hold its values.
- Wrap-around: sum is modulo 2^nBITS; cout carries bit nBITS. All-ones + 1 gives sum=0, cout=1.
- sub and cin are per-transaction and travel with their operands; mixed add/sub back-to-back is legal.

Test Plan:
- nBITS=4, GROUP=2, STAGES=2, out_ready=1:
  - Exhaustive ain, bin in 0..15, cin in {0,1}, sub=0, one operand set per cycle.
  - Every {cout,sum} == ain+bin+cin, in order, 2 cycles after acceptance; 512 checks, zero mismatches.
- nBITS=16, STAGES=4, single transaction:
  - ain=16'hFFFF, bin=16'h0001, cin=0, sub=0.
  - Required: sum=16'h0000, cout=1, ovf=0, out_valid rising exactly 4 cycles after acceptance.
- Subtract/overflow, nBITS=16:
  - ain=16'h8000, bin=16'h0001, cin=0, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
  - ain=16'h0003, bin=16'h0005, cin=1, sub=1 -> sum=16'hFFFD, cout=0, ovf=0.
- Backpressure:
  - Stream 8 sequential operand sets while out_ready toggles 1,0,0,1 repeatedly.
  - in_ready falls in the same cycle out_ready=0 with out_valid=1.
  - Held outputs stay unchanged; all 8 results emerge in order, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,0,0,1 with out_ready=1 -> out_valid reproduces the same pattern delayed by STAGES.
- Reset mid-operation:
  - Assert reset for 1 cycle with 3 operations in flight.
  - Following cycle: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - No stale result appears afterwards; the next transaction completes normally.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master is the datapath side (sources operands, sinks results); slave is the adder.
interface pipelined_cla_adder_if #(
    parameter int nBITS = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [nBITS-1:0] ain;
    logic [nBITS-1:0] bin;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [nBITS-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, ain, bin, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, ain, bin, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract: GROUP-bit lookahead groups spread over
// STAGES register stages, group carry handed stage to stage, global-stall handshake.
module pipelined_cla_adder #(
    parameter int nBITS  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic                  clk,
    input logic                  reset,
    pipelined_cla_adder_if.slave bus
);
    localparam int N_GROUPS = nBITS / GROUP;
    localparam int GPS      = N_GROUPS / STAGES;
    localparam int SLICE    = GPS * GROUP;
    localparam int SKEW     = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST     = STAGES - 1;

    typedef struct packed {
        logic [nBITS-1:0] sum;
        logic             cout;
    } stage_res_t;

    // Carries c[0..n] for the low n positions, each written as a flat sum of
    // products of generate/propagate terms so no carry waits on another.
    function automatic logic [nBITS:0] lookahead(input logic [nBITS-1:0] g,
                                                 input logic [nBITS-1:0] p,
                                                 input logic             c_in,
                                                 input int               n);
        logic [nBITS:0] c;
        logic           term;
        c = '0;
        for (int i = 0; i <= nBITS; i++) begin
            if (i <= n) begin
                term = c_in;
                for (int j = 0; j < nBITS; j++)
                    if (j < i) term = term & p[j];
                c[i] = term;
                for (int j = 0; j < nBITS; j++) begin
                    if (j < i) begin
                        term = g[j];
                        for (int m = 0; m < nBITS; m++)
                            if (m > j && m < i) term = term & p[m];
                        c[i] = c[i] | term;
                    end
                end
            end
        end
        return c;
    endfunction

    // Stage k: group G/P per group, lookahead across the stage's groups, then
    // bit carries inside each group from its group carry.
    function automatic stage_res_t stage_eval(input logic [nBITS-1:0] a_v,
                                              input logic [nBITS-1:0] b_v,
                                              input logic [nBITS-1:0] s_in,
                                              input logic             c_in,
                                              input int               k);
        stage_res_t       r;
        logic [nBITS-1:0] gg, gp, bg, bp;
        logic [nBITS:0]   gc, bc;
        int               base;
        r.sum = s_in;
        gg    = '0;
        gp    = '0;
        for (int j = 0; j < GPS; j++) begin
            base = k * SLICE + j * GROUP;
            bg   = '0;
            bp   = '0;
            for (int i = 0; i < GROUP; i++) begin
                bg[i] = a_v[base+i] & b_v[base+i];
                bp[i] = a_v[base+i] ^ b_v[base+i];
            end
            bc    = lookahead(bg, bp, 1'b0, GROUP);
            gg[j] = bc[GROUP];
            gp[j] = &bp[GROUP-1:0];
        end
        gc = lookahead(gg, gp, c_in, GPS);
        for (int j = 0; j < GPS; j++) begin
            base = k * SLICE + j * GROUP;
            bg   = '0;
            bp   = '0;
            for (int i = 0; i < GROUP; i++) begin
                bg[i] = a_v[base+i] & b_v[base+i];
                bp[i] = a_v[base+i] ^ b_v[base+i];
            end
            bc = lookahead(bg, bp, gc[j], GROUP);
            for (int i = 0; i < GROUP; i++)
                r.sum[base+i] = bp[i] ^ bc[i];
        end
        r.cout = gc[GPS];
        return r;
    endfunction

    logic             advance;
    logic [nBITS-1:0] a_at  [STAGES];
    logic [nBITS-1:0] b_at  [STAGES];
    logic [nBITS-1:0] s_at  [STAGES];
    logic             c_at  [STAGES];
    stage_res_t       res   [STAGES];
    logic             v_q   [STAGES];
    logic [nBITS-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic [nBITS-1:0] a_q   [SKEW];
    logic [nBITS-1:0] b_q   [SKEW];
    logic             ovf_q;
    logic             ovf_nxt;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign a_at[k] = bus.ain;
            assign b_at[k] = bus.sub ? ~bus.bin : bus.bin;
            assign s_at[k] = '0;
            assign c_at[k] = bus.sub ^ bus.cin;
        end else begin : g_inner
            assign a_at[k] = a_q[k-1];
            assign b_at[k] = b_q[k-1];
            assign s_at[k] = sum_q[k-1];
            assign c_at[k] = c_q[k-1];
        end
        assign res[k] = stage_eval(a_at[k], b_at[k], s_at[k], c_at[k], k);
    end

    // Carry into the MSB is recovered from the MSB's own operand and sum bits.
    assign ovf_nxt = a_at[LAST][nBITS-1] ^ b_at[LAST][nBITS-1]
                   ^ res[LAST].sum[nBITS-1] ^ res[LAST].cout;

    assign advance      = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data registers are cleared as well as valids so the output
            // registers read zero after reset; the pipe is only a few words deep.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
            for (int k = 0; k < SKEW; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++)
                v_q[k] <= v_q[k-1];
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= res[k].sum;
                c_q[k]   <= res[k].cout;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= a_at[k];
                b_q[k] <= b_at[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = sum_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
endmodule
